// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared FSM state encoding and register map for capture_ctrl
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } cap_state_e;

    localparam int CAP_ADDR_CTRL  = 0;
    localparam int CAP_ADDR_DELAY = 1;

    localparam int CTRL_ARM_BIT   = 0;
    localparam int CTRL_ABORT_BIT = 1;

endpackage

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - triggered stream capture with post-trigger delay; CAPTURE_ABORT_EN enables CTRL.ABORT
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int BDW = 32,
    parameter int BAW = 6,
    parameter int SDW = 32,
    parameter int CCW = 32
) (
    input  logic           clk,
    input  logic           rst,
    output logic           bus_wready,
    input  logic           bus_wvalid,
    input  logic [BAW-1:0] bus_waddr,
    input  logic [BDW-1:0] bus_wdata,
    output logic           sti_tready,
    input  logic           sti_tvalid,
    input  logic [1:0]     sti_tevent,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sto_tready,
    output logic           sto_tvalid,
    output logic [SDW-1:0] sto_tdata,
    output logic           sto_ttrig,
    output logic           sto_tlast,
    output logic [1:0]     sts_state
);

    cap_state_e     state_q, state_d;
    logic [CCW-1:0] cnt_q, cnt_d;
    logic [CCW-1:0] delay_q;
    logic           load, trig_d, last_d, in_xfer, fwd;
    logic           ctrl_wr, delay_wr, arm_wr;

    assign bus_wready = 1'b1;
    assign sts_state  = state_q;

    assign ctrl_wr  = bus_wvalid && bus_wready && (bus_waddr == BAW'(CAP_ADDR_CTRL));
    assign delay_wr = bus_wvalid && bus_wready && (bus_waddr == BAW'(CAP_ADDR_DELAY));
    assign arm_wr   = ctrl_wr && bus_wdata[CTRL_ARM_BIT];

`ifdef CAPTURE_ABORT_EN
    logic abort_wr;
    assign abort_wr = ctrl_wr && bus_wdata[CTRL_ABORT_BIT];
`endif

    // Event bit1 and the upper bus data bits carry nothing for this block.
    logic unused_bits;
    assign unused_bits = ^{sti_tevent[1], bus_wdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            delay_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (delay_wr) begin
                delay_q <= bus_wdata[CCW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        trig_d     = 1'b0;
        last_d     = 1'b0;
        fwd        = (state_q == ST_ARMED) || (state_q == ST_POST);
        sti_tready = fwd ? (!sto_tvalid || sto_tready) : 1'b1;
        in_xfer    = sti_tvalid && sti_tready;

        case (state_q)
            ST_IDLE: begin
                if (arm_wr) begin
                    state_d = ST_ARMED;
                    cnt_d   = delay_q;
                end
            end
            ST_ARMED: begin
                if (in_xfer) begin
                    load = 1'b1;
                    if (sti_tevent[0]) begin
                        trig_d = 1'b1;
                        if (cnt_q == '0) begin
                            last_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = cnt_q - CCW'(1);
                            state_d = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (in_xfer) begin
                    load = 1'b1;
                    if (cnt_q == '0) begin
                        last_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - CCW'(1);
                    end
                end
            end
            ST_DONE: begin
                // Leave only once the tlast beat has gone downstream.
                if (!sto_tvalid || sto_tready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef CAPTURE_ABORT_EN
        if (abort_wr) begin
            state_d = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sto_tvalid <= 1'b0;
            sto_tdata  <= '0;
            sto_ttrig  <= 1'b0;
            sto_tlast  <= 1'b0;
        end else if (load) begin
            sto_tvalid <= 1'b1;
            sto_tdata  <= sti_tdata;
            sto_ttrig  <= trig_d;
            sto_tlast  <= last_d;
        end else if (sto_tready) begin
            sto_tvalid <= 1'b0;
            sto_ttrig  <= 1'b0;
            sto_tlast  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - scoreboard bench for capture_ctrl against a capture-window reference model
module tb_capture_ctrl;

    localparam int BDW = 32;
    localparam int BAW = 6;
    localparam int SDW = 32;
    localparam int CCW = 32;

    logic           clk;
    logic           rst;
    logic           bus_wready;
    logic           bus_wvalid;
    logic [BAW-1:0] bus_waddr;
    logic [BDW-1:0] bus_wdata;
    logic           sti_tready;
    logic           sti_tvalid;
    logic [1:0]     sti_tevent;
    logic [SDW-1:0] sti_tdata;
    logic           sto_tready;
    logic           sto_tvalid;
    logic [SDW-1:0] sto_tdata;
    logic           sto_ttrig;
    logic           sto_tlast;
    logic [1:0]     sts_state;

    capture_ctrl #(.BDW(BDW), .BAW(BAW), .SDW(SDW), .CCW(CCW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_wready (bus_wready),
        .bus_wvalid (bus_wvalid),
        .bus_waddr  (bus_waddr),
        .bus_wdata  (bus_wdata),
        .sti_tready (sti_tready),
        .sti_tvalid (sti_tvalid),
        .sti_tevent (sti_tevent),
        .sti_tdata  (sti_tdata),
        .sto_tready (sto_tready),
        .sto_tvalid (sto_tvalid),
        .sto_tdata  (sto_tdata),
        .sto_ttrig  (sto_ttrig),
        .sto_tlast  (sto_tlast),
        .sts_state  (sts_state)
    );

    typedef struct {
        logic [SDW-1:0] data;
        logic           trig;
        logic           last;
    } beat_t;

    beat_t          exp_q[$];
    int             checks;
    int             errors;
    int             ready_mode;
    int             ready_cyc;
    logic [SDW-1:0] smp_data[64];
    bit             smp_trig[64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // 0: always ready, 1: pattern 1,0,0,1, 2: random, 3: never ready
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: sto_tready = 1'b1;
            1: sto_tready = (ready_cyc % 4 == 0) || (ready_cyc % 4 == 3);
            2: sto_tready = 1'($urandom_range(0, 1));
            default: sto_tready = 1'b0;
        endcase
        ready_cyc = ready_cyc + 1;
    end

    // Monitor: compare every presented beat (stalled or not) to the scoreboard head.
    always @(negedge clk) begin
        if (rst && sto_tvalid) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_beat got data=%h trig=%b last=%b want none",
                         sto_tdata, sto_ttrig, sto_tlast);
            end else begin
                if ({sto_tdata, sto_ttrig, sto_tlast} !== {exp_q[0].data, exp_q[0].trig, exp_q[0].last}) begin
                    errors = errors + 1;
                    $display("FAIL beat got data=%h trig=%b last=%b want data=%h trig=%b last=%b",
                             sto_tdata, sto_ttrig, sto_tlast, exp_q[0].data, exp_q[0].trig, exp_q[0].last);
                end
                if (sto_tready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic bus_write(input int addr, input logic [BDW-1:0] data);
        bus_wvalid = 1'b1;
        bus_waddr  = BAW'(addr);
        bus_wdata  = data;
        @(posedge clk);
        #1;
        bus_wvalid = 1'b0;
    endtask

    task automatic send_sample(input logic [SDW-1:0] d, input bit t);
        bit accepted;
        accepted   = 1'b0;
        sti_tvalid = 1'b1;
        sti_tdata  = d;
        sti_tevent = {1'($urandom_range(0, 1)), t};
        for (int k = 0; k < 100 && !accepted; k++) begin
            @(negedge clk);
            if (sti_tready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        sti_tvalid = 1'b0;
        sti_tevent = 2'b00;
        if (!accepted) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL input_timeout got no sti_tready want accept of %h", d);
        end
    endtask

    // Reference: everything before the first trigger, then the trigger and DELAY more samples.
    task automatic push_expected(input int n, input int delay);
        int t;
        int stop;
        beat_t b;
        t = -1;
        for (int i = n - 1; i >= 0; i--) if (smp_trig[i]) t = i;
        stop = (t < 0) ? n - 1 : t + delay;
        for (int i = 0; i < n && i <= stop; i++) begin
            b.data = smp_data[i];
            b.trig = (i == t);
            b.last = (t >= 0) && (i == stop);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_all(input int n);
        for (int i = 0; i < n; i++) send_sample(smp_data[i], smp_trig[i]);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sts_state !== 2'd0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("state_idle", 64'(sts_state), 64'd0);
    endtask

    task automatic fill(input logic [SDW-1:0] base, input int n, input int t);
        for (int i = 0; i < n; i++) begin
            smp_data[i] = base + SDW'(i);
            smp_trig[i] = (i == t);
        end
    endtask

    task automatic run_capture(input int delay, input int n);
        bus_write(1, BDW'(delay));
        bus_write(0, 32'h1);
        push_expected(n, delay);
        send_all(n);
        wait_drain();
        wait_idle();
    endtask

    initial begin
        int n, delay, npre;
        checks     = 0;
        errors     = 0;
        ready_mode = 0;
        ready_cyc  = 0;
        rst        = 1'b0;
        bus_wvalid = 1'b0;
        bus_waddr  = '0;
        bus_wdata  = '0;
        sti_tvalid = 1'b0;
        sti_tevent = 2'b00;
        sti_tdata  = '0;
        sto_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tvalid", 64'(sto_tvalid), 64'd0);
        check("reset_tdata", 64'(sto_tdata), 64'd0);
        check("reset_flags", 64'({sto_ttrig, sto_tlast}), 64'd0);
        check("reset_state", 64'(sts_state), 64'd0);
        check("wready_const", 64'(bus_wready), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_tready", 64'(sti_tready), 64'd1);

        // Unarmed: samples are swallowed, triggers ignored.
        fill(32'h100, 3, 1);
        send_all(3);
        repeat (2) @(posedge clk);
        #1;
        check("idle_discard_tvalid", 64'(sto_tvalid), 64'd0);
        check("idle_discard_state", 64'(sts_state), 64'd0);

        // DELAY=3, samples 1..10, trigger on 4.
        fill(32'd1, 10, 3);
        run_capture(3, 10);

        // DELAY=0, trigger on sample 2.
        fill(32'd1, 3, 1);
        run_capture(0, 3);

        // DELAY=2 under 1,0,0,1 back-pressure.
        ready_mode = 1;
        fill(32'd1, 6, 2);
        run_capture(2, 6);
        ready_mode = 0;

        // Extra triggers during POST are plain samples.
        fill(32'h200, 7, 1);
        smp_trig[2] = 1'b1;
        smp_trig[3] = 1'b1;
        run_capture(3, 7);

        // DELAY written while armed, and a re-arm, do not disturb the current capture.
        bus_write(1, 32'd2);
        bus_write(0, 32'h1);
        bus_write(1, 32'd5);
        bus_write(0, 32'h1);
        check("rearm_state", 64'(sts_state), 64'd1);
        fill(32'h300, 6, 1);
        push_expected(6, 2);
        send_all(6);
        wait_drain();
        wait_idle();
        bus_write(0, 32'h1);
        fill(32'h400, 8, 0);
        push_expected(8, 5);
        send_all(8);
        wait_drain();
        wait_idle();

        // Randomized captures under random back-pressure.
        ready_mode = 2;
        for (int r = 0; r < 10; r++) begin
            delay = $urandom_range(0, 4);
            npre  = $urandom_range(0, 4);
            n     = npre + 1 + delay + $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                smp_data[i] = $urandom;
                smp_trig[i] = (i == npre) || (i > npre && $urandom_range(0, 3) == 0);
            end
            run_capture(delay, n);
        end

        // Asynchronous reset while POST holds a stalled beat.
        ready_mode = 3;
        @(posedge clk);
        #1;
        bus_write(1, 32'd5);
        bus_write(0, 32'h1);
        fill(32'hAA, 1, 0);
        push_expected(1, 5);
        send_all(1);
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_state", 64'(sts_state), 64'd2);
        check("pre_reset_tvalid", 64'(sto_tvalid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_tvalid", 64'(sto_tvalid), 64'd0);
        check("async_reset_state", 64'(sts_state), 64'd0);
        check("async_reset_tdata", 64'(sto_tdata), 64'd0);
        exp_q.delete();
        ready_mode = 0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        fill(32'd20, 5, 2);
        run_capture(1, 5);

        // ABORT while armed.
        bus_write(1, 32'd2);
        bus_write(0, 32'h1);
        fill(32'd50, 2, -1);
        push_expected(2, 2);
        send_all(2);
        wait_drain();
`ifdef CAPTURE_ABORT_EN
        bus_write(0, 32'h3);
        check("abort_state", 64'(sts_state), 64'd0);
        fill(32'd52, 3, 0);
        send_all(3);
        repeat (3) @(posedge clk);
        #1;
        check("abort_discard_tvalid", 64'(sto_tvalid), 64'd0);
        check("abort_discard_state", 64'(sts_state), 64'd0);
`else
        bus_write(0, 32'h2);
        check("abort_ignored_state", 64'(sts_state), 64'd1);
        fill(32'd52, 4, 0);
        push_expected(4, 2);
        send_all(4);
        wait_drain();
        wait_idle();
`endif

        repeat (4) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- BDW 32 system bus data width.
- BAW 6 system bus address width.
- SDW 32 sample data width.
- CCW 32 post-trigger delay counter width, CCW <= BDW.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk in 1 single system clock.
- rst in 1 reset; asynchronous, active-low.
- bus_wready out 1 bus write ready.
- bus_wvalid in 1 bus write valid.
- bus_waddr in BAW bus write address.
- bus_wdata in BDW bus write data.
- sti_tready out 1 input stream ready; upstream is the trigger stage.
- sti_tvalid in 1 input stream valid.
- sti_tevent in 2 trigger events; bit0 = trigger fired, bit1 is ignored.
- sti_tdata in SDW input sample.
- sto_tready in 1 output stream ready.
- sto_tvalid out 1 output stream valid.
- sto_tdata out SDW output sample.
- sto_ttrig out 1 marks the trigger sample.
- sto_tlast out 1 marks the final sample of a capture.
- sts_state out 2 current FSM state encoding.

Function
REQ-003 A transfer occurs on any edge where valid and ready are both 1; bus_wready SHALL be constant 1.
REQ-004 Register map: addr 0 CTRL (bit0 ARM, bit1 ABORT; both write-pulse, not stored); addr 1 DELAY (CCW LSBs); all other addresses are ignored.
REQ-005 FSM states: IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-006 IDLE->ARMED on a CTRL write with ARM=1; DELAY is latched into the post counter at that edge.
REQ-007 ARM writes in ARMED or POST are ignored; a DELAY write takes effect only at the next arm.
REQ-008 In IDLE and DONE: sti_tready=1 and input samples are discarded.
REQ-009 In ARMED and POST, samples are forwarded through one output register stage:
- sti_tready = !sto_tvalid || sto_tready;
- latency is exactly 1 cycle from an input transfer to sto_tvalid.
REQ-010 ARMED->POST on an input transfer with sti_tevent[0]=1; that sample is forwarded with sto_ttrig=1.
REQ-011 In POST, each input transfer decrements the post counter. The sample transferred when the counter equals 0 carries sto_tlast=1 and moves the FSM to DONE.
REQ-012 With DELAY=0, the trigger sample itself carries both sto_ttrig=1 and sto_tlast=1, and ARMED goes directly to DONE.
REQ-013 sti_tevent[0] is ignored outside ARMED.
REQ-014 DONE->IDLE once the tlast beat is accepted downstream, or immediately if that beat has already been accepted.
REQ-015 Back-pressure: while sto_tvalid=1 and sto_tready=0, the sto_* outputs SHALL hold stable and no input is accepted.
REQ-016 The counter does not wrap: DELAY=2^CCW-1 yields exactly 2^CCW samples, trigger sample included.

Reset
REQ-017 On rst low:
- sto_tvalid, sto_ttrig, sto_tlast = 0 and sto_tdata = 0;
- state = IDLE; post counter and latched DELAY = 0.
REQ-018 Reset mid-capture discards any held output beat and SHALL take effect immediately, without waiting for a clock edge.

Configuration
REQ-019 Macro CAPTURE_ABORT_EN:
- Defined: a CTRL write with ABORT=1 forces IDLE on the next edge from any state. An already-held output beat stays valid until accepted, with its flags unchanged. ABORT takes priority over a simultaneous ARM in the same write.
- Undefined: the ABORT bit is ignored.

Structure
REQ-020 Package capture_pkg SHALL hold the FSM state enum and the register address constants CAP_ADDR_CTRL and CAP_ADDR_DELAY.
REQ-021 There SHALL be no sub-module; the output register stage is inline.

Verification
REQ-022 DELAY=3, arm, samples 1..10 with tevent[0] on sample 4, sto_tready=1 -> output 1..7; ttrig on 4, tlast on 7; sts_state returns to 0.
REQ-023 DELAY=0, trigger on sample 2 -> beat 2 has ttrig=1 and tlast=1; sample 3 is not output.
REQ-024 DELAY=2, sto_tready toggling 1,0,0,1 -> no sample lost or duplicated; sto_tdata stable while stalled.
REQ-025 Second tevent[0] during POST -> ttrig asserted only on the first trigger sample.
REQ-026 rst low while in POST with a held beat -> sto_tvalid=0 immediately; next arm starts a clean capture.
REQ-027 With CAPTURE_ABORT_EN, abort in ARMED -> state 0 next cycle and samples discarded; without it -> capture continues unchanged.
